// File: rtl/add_pkg.sv
// Shared sizing and FSM state type for the adder-sum accumulator stage.
package add_pkg;

  localparam int unsigned SUM_W = 5;
  localparam int unsigned NSAMP = 4;
  localparam int unsigned ACC_W = SUM_W + $clog2(NSAMP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sum_accum.sv
// Accumulates NSAMP unsigned adder sums into a frame total, average and maximum,
// then holds the result until the consumer acknowledges it.
module sum_accum #(
  parameter int unsigned SUM_W = add_pkg::SUM_W,
  parameter int unsigned NSAMP = add_pkg::NSAMP
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SUM_W-1:0]                sum_in,
  input  logic                            sum_vld,
  output logic                            in_rdy,
  output logic [SUM_W+$clog2(NSAMP)-1:0]  acc_out,
  output logic [SUM_W-1:0]                avg_out,
  output logic [SUM_W-1:0]                max_out,
  output logic                            out_vld,
  input  logic                            out_rdy
);

  import add_pkg::*;

  localparam int unsigned LOG2N = $clog2(NSAMP);
  localparam int unsigned ACC_W = SUM_W + LOG2N;
  localparam int unsigned CNT_W = $clog2(NSAMP + 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ACC_W-1:0]    total_q;
  logic [SUM_W-1:0]    max_q;
  logic                in_rdy_q;
  logic                out_vld_q;
  logic [ACC_W-1:0]    res_acc_q;
  logic [SUM_W-1:0]    res_avg_q;
  logic [SUM_W-1:0]    res_max_q;

  logic [ACC_W-1:0]    total_d;
  logic [SUM_W-1:0]    max_d;
  logic                accept;
  logic                last;

  always_comb begin
    total_d = total_q + ACC_W'(sum_in);
    // Strict compare: an equal sample keeps the existing maximum.
    max_d   = (sum_in > max_q) ? sum_in : max_q;
    accept  = sum_vld && in_rdy_q;
    last    = (cnt_q == CNT_W'(NSAMP - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      total_q   <= '0;
      max_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      res_acc_q <= '0;
      res_avg_q <= '0;
      res_max_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            total_q <= ACC_W'(sum_in);
            max_q   <= sum_in;
            cnt_q   <= CNT_W'(1);
            state_q <= ACC;
          end
        end
        ACC: begin
          if (accept) begin
            if (last) begin
              // Results are latched here so out_vld is visible the cycle after
              // the final sample; running state is cleared for the next frame.
              res_acc_q <= total_d;
              res_avg_q <= SUM_W'(total_d >> LOG2N);
              res_max_q <= max_d;
              out_vld_q <= 1'b1;
              in_rdy_q  <= 1'b0;
              total_q   <= '0;
              max_q     <= '0;
              cnt_q     <= '0;
              state_q   <= HOLD;
            end else begin
              total_q <= total_d;
              max_q   <= max_d;
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_rdy) begin
            res_acc_q <= '0;
            res_avg_q <= '0;
            res_max_q <= '0;
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_rdy_q  <= 1'b1;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = out_vld_q;
  assign acc_out = res_acc_q;
  assign avg_out = res_avg_q;
  assign max_out = res_max_q;

endmodule

// File: tb/tb_sum_accum.sv
// Self-checking bench for sum_accum: directed frames plus a randomized run
// against a queue-based frame model.
module tb_sum_accum;

  localparam int unsigned SUM_W = 5;
  localparam int unsigned NSAMP = 4;
  localparam int unsigned ACC_W = 7;

  logic             clk;
  logic             rst;
  logic [SUM_W-1:0] sum_in;
  logic             sum_vld;
  logic             in_rdy;
  logic [ACC_W-1:0] acc_out;
  logic [SUM_W-1:0] avg_out;
  logic [SUM_W-1:0] max_out;
  logic             out_vld;
  logic             out_rdy;

  int n_checks = 0;
  int n_errors = 0;

  // Frame model: accepted samples queue up; a full frame yields one result
  // that is held until acknowledged.
  int unsigned      q[$];
  bit               m_hold;
  logic [ACC_W-1:0] m_acc;
  logic [SUM_W-1:0] m_avg;
  logic [SUM_W-1:0] m_max;

  sum_accum #(.SUM_W(SUM_W), .NSAMP(NSAMP)) dut (
    .clk     (clk),
    .rst     (rst),
    .sum_in  (sum_in),
    .sum_vld (sum_vld),
    .in_rdy  (in_rdy),
    .acc_out (acc_out),
    .avg_out (avg_out),
    .max_out (max_out),
    .out_vld (out_vld),
    .out_rdy (out_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic v, input logic [SUM_W-1:0] d, input logic ordy);
    int unsigned s;
    int unsigned mx;
    if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (v) begin
      q.push_back(int'(d));
      if (q.size() == NSAMP) begin
        s = 0;
        mx = 0;
        foreach (q[i]) begin
          s += q[i];
          if (q[i] > mx) mx = q[i];
        end
        m_acc  = ACC_W'(s);
        m_avg  = SUM_W'(s / NSAMP);
        m_max  = SUM_W'(mx);
        m_hold = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [SUM_W-1:0] d, input logic ordy);
    sum_vld = v;
    sum_in  = d;
    out_rdy = ordy;
    model_edge(v, d, ordy);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    q.delete();
    m_hold = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sum_vld = 1'b0; sum_in = '0; out_rdy = 1'b0;
    m_hold = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_rdy !== 1'b1) begin $display("FAIL reset_in_rdy: got %0d expected 1", in_rdy); n_errors++; end
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL reset_out_vld: got %0d expected 0", out_vld); n_errors++; end
    n_checks++; if (acc_out !== '0) begin $display("FAIL reset_acc: got %0d expected 0", acc_out); n_errors++; end
    rst = 1'b0;
    // Reset while holding a result must clear it without waiting for a clock.
    cyc(1, 5, 0); cyc(1, 6, 0); cyc(1, 7, 0); cyc(1, 8, 0);
    n_checks++; if (out_vld !== 1'b1) begin $display("FAIL reset_prehold_vld: got %0d expected 1", out_vld); n_errors++; end
    sum_vld = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL reset_async_vld: got %0d expected 0", out_vld); n_errors++; end
    n_checks++; if (in_rdy !== 1'b1) begin $display("FAIL reset_async_rdy: got %0d expected 1", in_rdy); n_errors++; end
    n_checks++; if (acc_out !== '0 || max_out !== '0 || avg_out !== '0) begin
      $display("FAIL reset_async_results: got acc=%0d avg=%0d max=%0d expected 0", acc_out, avg_out, max_out); n_errors++; end
    rst = 1'b0;
    q.delete();
    m_hold = 1'b0;
  endtask

  task automatic test_basic_frame();
    cyc(1, 6, 1); cyc(1, 8, 1); cyc(1, 9, 1);
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL basic_early_vld: got %0d expected 0", out_vld); n_errors++; end
    cyc(1, 11, 1);
    n_checks++; if (out_vld !== 1'b1) begin $display("FAIL basic_vld: got %0d expected 1", out_vld); n_errors++; end
    n_checks++; if (acc_out !== 7'd34) begin $display("FAIL basic_acc: got %0d expected 34", acc_out); n_errors++; end
    n_checks++; if (avg_out !== 5'd8) begin $display("FAIL basic_avg: got %0d expected 8", avg_out); n_errors++; end
    n_checks++; if (max_out !== 5'd11) begin $display("FAIL basic_max: got %0d expected 11", max_out); n_errors++; end
    n_checks++; if (in_rdy !== 1'b0) begin $display("FAIL basic_hold_rdy: got %0d expected 0", in_rdy); n_errors++; end
    cyc(0, 0, 1);
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL basic_vld_one_cycle: got %0d expected 0", out_vld); n_errors++; end
    n_checks++; if (acc_out !== '0) begin $display("FAIL basic_acc_cleared: got %0d expected 0", acc_out); n_errors++; end
  endtask

  task automatic test_max_values();
    for (int i = 0; i < 4; i++) cyc(1, 31, 0);
    n_checks++; if (acc_out !== 7'd124) begin $display("FAIL max_acc: got %0d expected 124", acc_out); n_errors++; end
    n_checks++; if (avg_out !== 5'd31) begin $display("FAIL max_avg: got %0d expected 31", avg_out); n_errors++; end
    n_checks++; if (max_out !== 5'd31) begin $display("FAIL max_max: got %0d expected 31", max_out); n_errors++; end
    cyc(0, 0, 1);
  endtask

  task automatic test_backpressure();
    cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0); cyc(1, 4, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 9, 0);
      n_checks++; if (in_rdy !== 1'b0 || out_vld !== 1'b1) begin
        $display("FAIL bp_hold_flags[%0d]: got in_rdy=%0d out_vld=%0d expected 0/1", i, in_rdy, out_vld); n_errors++; end
      n_checks++; if (acc_out !== 7'd10 || avg_out !== 5'd2 || max_out !== 5'd4) begin
        $display("FAIL bp_stable[%0d]: got acc=%0d avg=%0d max=%0d expected 10/2/4", i, acc_out, avg_out, max_out); n_errors++; end
    end
    cyc(1, 9, 1);
    n_checks++; if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      $display("FAIL bp_release: got in_rdy=%0d out_vld=%0d expected 1/0", in_rdy, out_vld); n_errors++; end
    cyc(1, 2, 0); cyc(1, 2, 0); cyc(1, 2, 0); cyc(1, 2, 0);
    n_checks++; if (out_vld !== 1'b1 || acc_out !== 7'd8 || max_out !== 5'd2) begin
      $display("FAIL bp_next_frame: got vld=%0d acc=%0d max=%0d expected 1/8/2", out_vld, acc_out, max_out); n_errors++; end
    cyc(0, 0, 1);
  endtask

  task automatic test_gaps();
    cyc(1, 3, 1); cyc(0, 0, 1); cyc(0, 0, 1);
    n_checks++; if (out_vld !== 1'b0 || acc_out !== '0) begin
      $display("FAIL gap_idle_outputs: got vld=%0d acc=%0d expected 0/0", out_vld, acc_out); n_errors++; end
    cyc(1, 5, 1); cyc(1, 0, 1); cyc(0, 0, 1); cyc(1, 2, 1);
    n_checks++; if (acc_out !== 7'd10 || avg_out !== 5'd2 || max_out !== 5'd5) begin
      $display("FAIL gap_result: got acc=%0d avg=%0d max=%0d expected 10/2/5", acc_out, avg_out, max_out); n_errors++; end
    cyc(0, 0, 1);
  endtask

  task automatic test_mid_reset();
    cyc(1, 7, 0); cyc(1, 7, 0);
    pulse_reset();
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    n_checks++; if (out_vld !== 1'b1 || acc_out !== 7'd4 || avg_out !== 5'd1 || max_out !== 5'd1) begin
      $display("FAIL midreset_result: got vld=%0d acc=%0d avg=%0d max=%0d expected 1/4/1/1", out_vld, acc_out, avg_out, max_out); n_errors++; end
    cyc(0, 0, 1);
  endtask

  task automatic test_collision();
    cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
    cyc(1, 7, 1);
    cyc(1, 2, 0); cyc(1, 2, 0); cyc(1, 2, 0);
    n_checks++; if (out_vld !== 1'b0) begin $display("FAIL collision_early_vld: got %0d expected 0", out_vld); n_errors++; end
    cyc(1, 2, 0);
    n_checks++; if (acc_out !== 7'd8 || max_out !== 5'd2) begin
      $display("FAIL collision_result: got acc=%0d max=%0d expected 8/2", acc_out, max_out); n_errors++; end
    cyc(0, 0, 1);
  endtask

  task automatic test_random();
    logic [SUM_W-1:0] exp_acc_avg_max_dummy;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 7), SUM_W'($urandom), ($urandom_range(0, 1) == 1));
      exp_acc_avg_max_dummy = m_hold ? m_max : '0;
      n_checks++; if (out_vld !== m_hold || in_rdy !== !m_hold) begin
        $display("FAIL rand_flags[%0d]: got vld=%0d rdy=%0d expected %0d/%0d", i, out_vld, in_rdy, m_hold, !m_hold); n_errors++; end
      n_checks++; if (acc_out !== (m_hold ? m_acc : '0) || avg_out !== (m_hold ? m_avg : '0) || max_out !== exp_acc_avg_max_dummy) begin
        $display("FAIL rand_results[%0d]: got acc=%0d avg=%0d max=%0d expected %0d/%0d/%0d", i, acc_out, avg_out, max_out,
                 m_hold ? m_acc : 7'd0, m_hold ? m_avg : 5'd0, exp_acc_avg_max_dummy); n_errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_max_values();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sum_accum.md
SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 SHALL have parameter SUM_W, default 5, width of the adder sum consumed.
REQ-002 SHALL have parameter NSAMP, default 4, samples per frame; power of two, range 2..16.
REQ-003 SHALL derive ACC_W = SUM_W + $clog2(NSAMP), default 7.
REQ-004 SHALL have port clk  input  1  sole clock; all state on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port sum_in  input  SUM_W  registered sum from the upstream adder stage.
REQ-007 SHALL have port sum_vld  input  1  sum_in valid this cycle.
REQ-008 SHALL have port in_rdy  output  1  block can accept a sample this cycle.
REQ-009 SHALL have port acc_out  output  ACC_W  frame total.
REQ-010 SHALL have port avg_out  output  SUM_W  frame average.
REQ-011 SHALL have port max_out  output  SUM_W  frame maximum.
REQ-012 SHALL have port out_vld  output  1  frame result valid.
REQ-013 SHALL have port out_rdy  input  1  consumer accepts the result.

Function
REQ-014 SHALL accept a sample only in a cycle where sum_vld=1 and in_rdy=1.
REQ-015 SHALL implement FSM states IDLE, ACC and HOLD.
REQ-016 IDLE: in_rdy=1; on accept, total<=sum_in, max<=sum_in, cnt<=1, go to ACC.
REQ-017 ACC: in_rdy=1; on accept, total<=total+sum_in, max<=larger of max and sum_in, cnt<=cnt+1.
REQ-018 ACC: on accepting sample number NSAMP, SHALL go to HOLD and latch the results.
REQ-019 Latency: out_vld SHALL rise on the clock edge that accepts sample NSAMP, so it is visible the following cycle.
REQ-020 HOLD: out_vld=1 and in_rdy=0; acc_out, avg_out and max_out SHALL hold stable until the handshake.
REQ-021 HOLD: on out_rdy=1, SHALL go to IDLE and drop out_vld on the next cycle.
REQ-022 HOLD: a sample presented in the same cycle as out_rdy=1 SHALL NOT be accepted; there is no bypass.
REQ-023 SHALL compute avg_out = acc_out >> log2(NSAMP), truncating.
REQ-024 Arithmetic SHALL be unsigned and SHALL never overflow, since ACC_W covers NSAMP*(2^SUM_W - 1).
REQ-025 Outside HOLD, acc_out, avg_out and max_out SHALL read 0.
REQ-026 In ACC or IDLE, sum_vld=0 SHALL leave all state unchanged; sample gaps are allowed.
REQ-027 Equal samples: max SHALL keep the existing value.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, cnt=0, total=0, max=0, out_vld=0, in_rdy=1, and all result outputs to 0.
REQ-029 Reset mid-frame or in HOLD SHALL discard the partial frame or unacknowledged result.
REQ-030 The first sample SHALL be accepted on the first posedge clk after rst deasserts.

Structure
REQ-031 A shared package add_pkg SHALL hold SUM_W, NSAMP, ACC_W and the FSM state enum.
REQ-032 The block SHALL be a single module with no sub-module.
REQ-033 The block SHALL connect through the existing interface: sum_in to the adder's sum output, plus added signals sum_vld, in_rdy, out_vld and out_rdy.

Verification
REQ-034 Basic frame: NSAMP=4, samples 6, 8, 9, 11 back-to-back, out_rdy=1 -> acc_out=34, avg_out=8, max_out=11, out_vld high exactly 1 cycle.
REQ-035 Maximum values: four samples of 31 -> acc_out=124, avg_out=31, max_out=31, with no wrap.
REQ-036 Backpressure: out_rdy=0 for 5 cycles while sum_vld=1 -> in_rdy=0, outputs stable, no sample taken; after out_rdy=1, the next frame starts the cycle after IDLE is reached.
REQ-037 Sample gaps: samples 3, _, _, 5, 0, _, 2 (_ = sum_vld=0) -> acc_out=10, avg_out=2, max_out=5.
REQ-038 Mid-frame reset: rst pulsed after 2 of 4 samples, then 1, 1, 1, 1 -> acc_out=4, with no carry-over from the discarded samples.
REQ-039 HOLD/ACK collision: out_rdy=1 and sum_vld=1 with sum_in=7 in the same HOLD cycle -> the 7 is not counted, and the next frame total excludes it.
